// File: rtl/lo_gray_divider_pkg.sv
// Shared definitions for the LO Gray divider slice.
// - LO default widths.
// - Count-direction enum.
// - bin2gray / gray2bin helpers. They work on a 32-bit word, so any WIDTH up
//   to 32 is handled by zero-extending on the way in and truncating on the
//   way out.
package lo_gray_divider_pkg;

  localparam int LO_WIDTH = 8;
  localparam int LO_PRE_W = 4;
  localparam int LO_MAX_W = 32;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  typedef logic [LO_MAX_W-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    word_t g;
    for (int i = 0; i < LO_MAX_W - 1; i++) g[i] = b[i] ^ b[i+1];
    g[LO_MAX_W-1] = b[LO_MAX_W-1];
    return g;
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[LO_MAX_W-1] = g[LO_MAX_W-1];
    for (int i = LO_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/lo_gray_divider_if.sv
// Control and status bundle of the LO Gray divider.
// - master: the phase-select controller. It drives enable, direction,
//   prescaler ratio, clear and load, and observes the count and pulses.
// - slave: the divider itself.
interface lo_gray_divider_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) ();
  logic             en_i;
  logic             up_i;
  logic [PRE_W-1:0] div_i;
  logic             sync_clr_i;
  logic             load_i;
  logic [WIDTH-1:0] load_gray_i;
  logic [WIDTH-1:0] gray_o;
  logic [WIDTH-1:0] bin_o;
  logic             tick_o;
  logic             wrap_o;

  modport master (
    output en_i, up_i, div_i, sync_clr_i, load_i, load_gray_i,
    input  gray_o, bin_o, tick_o, wrap_o
  );

  modport slave (
    input  en_i, up_i, div_i, sync_clr_i, load_i, load_gray_i,
    output gray_o, bin_o, tick_o, wrap_o
  );
endinterface

// File: rtl/lo_gray_divider_prescaler.sv
// Programmable prescaler for the LO Gray divider.
// Ports:
//   clk, rstb  clock and async active-low reset
//   en         count enable; low freezes pcnt
//   clr        synchronous clear of pcnt (ignores en)
//   div        ratio minus one; a tick fires every div+1 enabled cycles
//   tick       combinational tick, consumed by the counter on this edge
module lo_gray_divider_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);
  logic [PRE_W-1:0] pcnt;

  // The >= compare means lowering div mid-count ticks at once instead of
  // running pcnt around its full range.
  assign tick = en & ~clr & (pcnt >= div);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)            pcnt <= '0;
    else if (clr)         pcnt <= '0;
    else if (en) begin
      if (pcnt >= div)    pcnt <= '0;
      else                pcnt <= pcnt + PRE_W'(1);
    end
  end
endmodule

// File: rtl/lo_gray_divider.sv
// lo_gray_divider: synchronous up/down Gray-code counter for the LO path.
// - Each gray_o bit is a glitch-free divided clock.
// - The Gray register is loaded from the next binary value, so exactly one
//   bit changes per tick and no decode logic sits on gray_o.
// Ports:
//   clk   master LO clock, all state on posedge
//   rstb  asynchronous active-low reset
//   bus   lo_gray_divider_if.slave. Carries en/up/div/sync_clr/load/load_gray
//         in and gray/bin/tick/wrap out; all outputs are registered.
module lo_gray_divider
  import lo_gray_divider_pkg::*;
#(
  parameter int WIDTH = LO_WIDTH,
  parameter int PRE_W = LO_PRE_W
) (
  input  logic                  clk,
  input  logic                  rstb,
  lo_gray_divider_if.slave      bus
);
  logic             ptick;
  logic             wrap_hit;
  logic             tick_q, wrap_q;
  logic [WIDTH-1:0] bin_q, gray_q, next_bin, load_bin;
  dir_e             dir;

  // A load also restarts the prescaler so the next tick is a full period away.
  lo_gray_divider_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk  (clk),
    .rstb (rstb),
    .en   (bus.en_i),
    .clr  (bus.sync_clr_i | bus.load_i),
    .div  (bus.div_i),
    .tick (ptick)
  );

  assign dir      = dir_e'(bus.up_i);
  assign load_bin = WIDTH'(gray2bin(word_t'(bus.load_gray_i)));

  always_comb begin
    next_bin = bin_q - WIDTH'(1);
    wrap_hit = ~|bin_q;
    if (dir == DIR_UP) begin
      next_bin = bin_q + WIDTH'(1);
      wrap_hit = &bin_q;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bin_q  <= '0;
      gray_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (bus.sync_clr_i) begin
      bin_q  <= '0;
      gray_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (bus.load_i) begin
      // Load preempts any tick in the same cycle, so no tick pulse follows.
      bin_q  <= load_bin;
      gray_q <= bus.load_gray_i;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (ptick) begin
      bin_q  <= next_bin;
      gray_q <= WIDTH'(bin2gray(word_t'(next_bin)));
      tick_q <= 1'b1;
      wrap_q <= wrap_hit;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  assign bus.gray_o = gray_q;
  assign bus.bin_o  = bin_q;
  assign bus.tick_o = tick_q;
  assign bus.wrap_o = wrap_q;
endmodule

// File: tb/tb_lo_gray_divider.sv
// Self-checking bench for lo_gray_divider (WIDTH=8, PRE_W=4).
// A behavioural model advances on every step and pushes its expected outputs
// to a queue. Each scenario task pops the queue after the edge and compares.
module tb_lo_gray_divider;
  localparam int W = 8;
  localparam int P = 4;

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         tick;
    logic         wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t sbq[$];
  exp_t e;

  // model state
  int   mp = 0;
  int   mb = 0;
  logic mt = 1'b0;
  logic mw = 1'b0;
  int   mwraps = 0;
  int   dwraps = 0;

  lo_gray_divider_if #(.WIDTH(W), .PRE_W(P)) bus ();

  lo_gray_divider #(.WIDTH(W), .PRE_W(P)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int m_g2b(input int g);
    int b = 0;
    for (int i = W - 1; i >= 0; i--) b[i] = ((i == W - 1) ? 1'b0 : b[i+1]) ^ g[i];
    return b;
  endfunction

  function automatic int m_gray(input int b);
    return (b ^ (b >> 1)) & ((1 << W) - 1);
  endfunction

  // Advance the model with the currently driven inputs, queue the expectation,
  // then move to 1 time unit after the rising edge.
  task automatic step();
    exp_t x;
    if (bus.sync_clr_i) begin
      mp = 0; mb = 0; mt = 1'b0; mw = 1'b0;
    end else if (bus.load_i) begin
      mb = m_g2b(int'(bus.load_gray_i)); mp = 0; mt = 1'b0; mw = 1'b0;
    end else if (bus.en_i && mp >= int'(bus.div_i)) begin
      mw = bus.up_i ? (mb == (1 << W) - 1) : (mb == 0);
      mb = (bus.up_i ? mb + 1 : mb - 1) & ((1 << W) - 1);
      mp = 0; mt = 1'b1;
    end else begin
      if (bus.en_i) mp++;
      mt = 1'b0; mw = 1'b0;
    end
    if (mw) mwraps++;
    x.gray = W'(m_gray(mb));
    x.bin  = W'(mb);
    x.tick = mt;
    x.wrap = mw;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (bus.wrap_o) dwraps++;
  endtask

  task automatic drive(input logic en, input logic up, input int div,
                       input logic clr, input logic ld, input logic [W-1:0] lg);
    bus.en_i        = en;
    bus.up_i        = up;
    bus.div_i       = P'(div);
    bus.sync_clr_i  = clr;
    bus.load_i      = ld;
    bus.load_gray_i = lg;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 0, 1'b0, 1'b0, '0);
    #3;
    checks++;
    if ({bus.gray_o, bus.bin_o, bus.tick_o, bus.wrap_o} !== '0) begin
      errors++;
      $display("FAIL reset_initial gray=%h bin=%h tick=%b wrap=%b expected all 0",
               bus.gray_o, bus.bin_o, bus.tick_o, bus.wrap_o);
    end
    @(negedge clk) rstb = 1'b1;
    bus.en_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      e = sbq.pop_front();
      checks++;
      if (bus.gray_o !== e.gray || bus.bin_o !== e.bin || bus.tick_o !== e.tick || bus.wrap_o !== e.wrap) begin
        errors++;
        $display("FAIL reset_count[%0d] got g=%h b=%h t=%b w=%b want g=%h b=%h t=%b w=%b", i,
                 bus.gray_o, bus.bin_o, bus.tick_o, bus.wrap_o, e.gray, e.bin, e.tick, e.wrap);
      end
    end
    // asynchronous assertion between edges
    #2 rstb = 1'b0;
    #1;
    checks++;
    if ({bus.gray_o, bus.bin_o, bus.tick_o, bus.wrap_o} !== '0) begin
      errors++;
      $display("FAIL reset_async gray=%h bin=%h tick=%b wrap=%b expected all 0",
               bus.gray_o, bus.bin_o, bus.tick_o, bus.wrap_o);
    end
    mp = 0; mb = 0; mt = 1'b0; mw = 1'b0;
    @(negedge clk) rstb = 1'b1;
    step();
    e = sbq.pop_front();
    checks++;
    if (bus.bin_o !== 8'h01 || bus.gray_o !== 8'h01 || e.bin !== 8'h01) begin
      errors++;
      $display("FAIL reset_restart got bin=%h gray=%h want bin=01 gray=01", bus.bin_o, bus.gray_o);
    end
  endtask

  task automatic test_up_sweep();
    logic [W-1:0] prev;
    int wraps = 0;
    drive(1'b1, 1'b1, 0, 1'b1, 1'b0, '0);
    step();
    void'(sbq.pop_front());
    bus.sync_clr_i = 1'b0;
    prev = bus.gray_o;
    for (int i = 1; i <= 260; i++) begin
      step();
      e = sbq.pop_front();
      checks++;
      if (bus.gray_o !== e.gray || bus.bin_o !== e.bin || bus.tick_o !== e.tick || bus.wrap_o !== e.wrap) begin
        errors++;
        $display("FAIL up_sweep[%0d] got g=%h b=%h t=%b w=%b want g=%h b=%h t=%b w=%b", i,
                 bus.gray_o, bus.bin_o, bus.tick_o, bus.wrap_o, e.gray, e.bin, e.tick, e.wrap);
      end
      checks++;
      if ($countones(bus.gray_o ^ prev) != 1) begin
        errors++;
        $display("FAIL up_one_bit[%0d] got %h -> %h want single-bit change", i, prev, bus.gray_o);
      end
      if (bus.wrap_o) wraps++;
      prev = bus.gray_o;
    end
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL up_wrap_count got %0d want 1", wraps);
    end
  endtask

  task automatic test_prescaler();
    drive(1'b1, 1'b1, 3, 1'b1, 1'b0, '0);
    step();
    void'(sbq.pop_front());
    bus.sync_clr_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      e = sbq.pop_front();
      checks++;
      if (bus.tick_o !== ((i % 4) == 3) || bus.tick_o !== e.tick || bus.bin_o !== e.bin) begin
        errors++;
        $display("FAIL pre_div3[%0d] got t=%b b=%h want t=%b b=%h", i, bus.tick_o, bus.bin_o,
                 e.tick, e.bin);
      end
    end
    // ticks landed on i=3 and i=7; pcnt is now 2
    bus.div_i = P'(1);
    for (int i = 0; i < 6; i++) begin
      step();
      e = sbq.pop_front();
      checks++;
      if (bus.tick_o !== ((i % 2) == 0) || bus.tick_o !== e.tick || bus.bin_o !== e.bin) begin
        errors++;
        $display("FAIL pre_div1[%0d] got t=%b b=%h want t=%b b=%h", i, bus.tick_o, bus.bin_o,
                 e.tick, e.bin);
      end
    end
  endtask

  task automatic test_down();
    logic [W-1:0] wb [3];
    logic [W-1:0] wg [3];
    wb[0] = 8'hFF; wb[1] = 8'hFE; wb[2] = 8'hFF;
    wg[0] = 8'h80; wg[1] = 8'h81; wg[2] = 8'h80;
    drive(1'b1, 1'b0, 0, 1'b1, 1'b0, '0);
    step();
    void'(sbq.pop_front());
    bus.sync_clr_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.up_i = 1'b1;
      step();
      e = sbq.pop_front();
      checks++;
      if (bus.bin_o !== wb[i] || bus.gray_o !== wg[i] || bus.wrap_o !== (i == 0) || e.bin !== wb[i]) begin
        errors++;
        $display("FAIL down[%0d] got b=%h g=%h w=%b want b=%h g=%h w=%b", i,
                 bus.bin_o, bus.gray_o, bus.wrap_o, wb[i], wg[i], (i == 0));
      end
    end
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 0, 1'b1, 1'b1, 8'hC3);
    step();
    e = sbq.pop_front();
    checks++;
    if (bus.bin_o !== 8'h00 || bus.gray_o !== 8'h00 || e.bin !== 8'h00) begin
      errors++;
      $display("FAIL load_vs_clr got b=%h g=%h want b=00 g=00", bus.bin_o, bus.gray_o);
    end
    bus.sync_clr_i = 1'b0;
    step();
    e = sbq.pop_front();
    checks++;
    if (bus.bin_o !== 8'h82 || bus.gray_o !== 8'hC3 || bus.tick_o !== 1'b0 || e.bin !== 8'h82) begin
      errors++;
      $display("FAIL load_c3 got b=%h g=%h t=%b want b=82 g=c3 t=0", bus.bin_o, bus.gray_o, bus.tick_o);
    end
    bus.load_i = 1'b0;
    step();
    e = sbq.pop_front();
    checks++;
    if (bus.bin_o !== 8'h83 || bus.gray_o !== 8'hC2 || bus.tick_o !== 1'b1) begin
      errors++;
      $display("FAIL load_continue got b=%h g=%h t=%b want b=83 g=c2 t=1", bus.bin_o, bus.gray_o, bus.tick_o);
    end
  endtask

  task automatic test_random();
    mwraps = 0;
    dwraps = 0;
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0, W'($urandom));
      step();
      e = sbq.pop_front();
      checks++;
      if (bus.gray_o !== e.gray || bus.bin_o !== e.bin || bus.tick_o !== e.tick || bus.wrap_o !== e.wrap) begin
        errors++;
        $display("FAIL random[%0d] got g=%h b=%h t=%b w=%b want g=%h b=%h t=%b w=%b", i,
                 bus.gray_o, bus.bin_o, bus.tick_o, bus.wrap_o, e.gray, e.bin, e.tick, e.wrap);
      end
    end
    checks++;
    if (dwraps != mwraps) begin
      errors++;
      $display("FAIL random_wraps got %0d want %0d", dwraps, mwraps);
    end
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_prescaler();
    test_down();
    test_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
